mpaddsub_seq: RTL and testbench

Parametrised multi-cycle multiprecision adder/subtractor for the Montgomery datapath. It processes DATA_WIDTH-bit operands in ADDER_SIZE-bit chunks over CYCLES clock cycles. It supports add, subtract and reverse-subtract modes, a start/busy/done handshake, and borrow/carry reporting. It is the drop-in successor of the fixed 1027-bit adder and is instantiated by the Montgomery multiplier and the final-reduction stage.

---
 rtl/mpaddsub_seq_pkg.sv | 21 ++
 rtl/mpaddsub_seq_if.sv | 27 ++
 rtl/mpaddsub_seq_chunk_adder.sv | 19 +
 rtl/mpaddsub_seq.sv | 182 ++++++++++++++++++
 tb/tb_mpaddsub_seq.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpaddsub_seq_pkg.sv
// Shared definitions for the multiprecision add/sub datapath:
// operation mode encoding, controller state encoding and chunk-count helper.
package mpadd_pkg;

  // Operation select; the fourth code is reserved and behaves as ADD.
  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_SUB  = 2'd1;
  localparam logic [1:0] MODE_RSUB = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of chunk additions needed to cover data_width bits.
  function automatic int cycles(input int data_width, input int adder_size);
    return (data_width + adder_size - 1) / adder_size;
  endfunction

endpackage

// File: rtl/mpaddsub_seq_if.sv
// Request/response bundle of the multiprecision add/sub unit.
// The zero-result flag exists only when MPADDER_ZERO_FLAG_EN is defined.
interface mpaddsub_seq_if #(
  parameter int DATA_WIDTH = 1027
);
  logic                  start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH:0]   result;
  logic                  borrow;
  logic                  busy;
  logic                  done;
`ifdef MPADDER_ZERO_FLAG_EN
  logic                  zero;

  modport master (output start, mode, in_a, in_b,
                  input  result, borrow, busy, done, zero);
  modport slave  (input  start, mode, in_a, in_b,
                  output result, borrow, busy, done, zero);
`else
  modport master (output start, mode, in_a, in_b,
                  input  result, borrow, busy, done);
  modport slave  (input  start, mode, in_a, in_b,
                  output result, borrow, busy, done);
`endif
endinterface

// File: rtl/mpaddsub_seq_chunk_adder.sv
// mp_chunk_adder: combinational ADDER_SIZE-bit adder with optional
// inversion of the B operand, carry-in and carry-out. Subtraction is
// a + ~b + 1, obtained with invert_b_i=1 and carry_i=1.
module mp_chunk_adder #(
  parameter int ADDER_SIZE = 257
) (
  input  logic [ADDER_SIZE-1:0] a_i,
  input  logic [ADDER_SIZE-1:0] b_i,
  input  logic                  invert_b_i,
  input  logic                  carry_i,
  output logic [ADDER_SIZE-1:0] sum_o,
  output logic                  carry_o
);
  logic [ADDER_SIZE-1:0] b_eff;

  assign b_eff = invert_b_i ? ~b_i : b_i;
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff}
                          + {{ADDER_SIZE{1'b0}}, carry_i};
endmodule

// File: rtl/mpaddsub_seq.sv
// mpaddsub_seq: multi-cycle multiprecision adder / subtractor.
// Operands are latched at start, zero-padded to a whole number of chunks and
// consumed ADDER_SIZE bits per cycle, least significant chunk first. Each
// chunk sum is shifted into the top of the accumulator, so after the last
// chunk the accumulator holds the full padded sum.
// Optional feature: define MPADDER_ZERO_FLAG_EN to add the zero output.
module mpaddsub_seq
  import mpadd_pkg::*;
#(
  parameter int DATA_WIDTH = 1027,
  parameter int ADDER_SIZE = 257
) (
  input logic           clk,
  input logic           reset,
  mpaddsub_seq_if.slave bus
);
  localparam int CYCLES    = cycles(DATA_WIDTH, ADDER_SIZE);
  localparam int PAD_WIDTH = CYCLES * ADDER_SIZE;
  localparam int CNT_W     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(CYCLES - 1);
  localparam logic [PAD_WIDTH-1:0] VALID_MASK = PAD_WIDTH'({DATA_WIDTH{1'b1}});

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PAD_WIDTH-1:0]  x_q, x_d;       // addend / minuend
  logic [PAD_WIDTH-1:0]  y_q, y_d;       // addend / subtrahend
  logic [PAD_WIDTH-1:0]  acc_q, acc_d;   // result shift register
  logic                  sub_q, sub_d;
  logic                  carry_q, carry_d;
  logic                  borrow_q, borrow_d;

  logic [DATA_WIDTH-1:0] minuend, subtrahend;
  logic                  op_is_sub;
  logic [ADDER_SIZE-1:0] chunk_sum;
  logic                  chunk_cout;
  logic [PAD_WIDTH-1:0]  acc_shift;
  logic                  sum_top;        // padded-sum bit DATA_WIDTH after this chunk

`ifdef MPADDER_ZERO_FLAG_EN
  localparam int LAST_BITS = DATA_WIDTH - (CYCLES - 1) * ADDER_SIZE;
  localparam logic [ADDER_SIZE-1:0] LAST_MASK = ADDER_SIZE'({LAST_BITS{1'b1}});
  logic zacc_q, zacc_d;
  logic zero_q, zero_d;
  logic chunk_zero;

  // Padding bits of the final chunk carry the carry/no-borrow bit, so mask them.
  assign chunk_zero = ((chunk_sum & ((cnt_q == LAST_CNT) ? LAST_MASK : '1)) == '0);
  assign bus.zero   = zero_q;
`endif

  // Route operands so the chunk adder always computes x + y or x + ~y + 1.
  always_comb begin
    op_is_sub  = (bus.mode == MODE_SUB) || (bus.mode == MODE_RSUB);
    minuend    = bus.in_a;
    subtrahend = bus.in_b;
    if (bus.mode == MODE_RSUB) begin
      minuend    = bus.in_b;
      subtrahend = bus.in_a;
    end
  end

  mp_chunk_adder #(.ADDER_SIZE(ADDER_SIZE)) u_chunk (
    .a_i       (x_q[ADDER_SIZE-1:0]),
    .b_i       (y_q[ADDER_SIZE-1:0]),
    .invert_b_i(sub_q),
    .carry_i   (carry_q),
    .sum_o     (chunk_sum),
    .carry_o   (chunk_cout)
  );

  generate
    if (CYCLES == 1) begin : g_single
      assign acc_shift = chunk_sum;
    end else begin : g_multi
      assign acc_shift = {chunk_sum, acc_q[PAD_WIDTH-1:ADDER_SIZE]};
    end

    // Without padding, bit DATA_WIDTH of the sum is the last chunk's carry-out.
    if (PAD_WIDTH == DATA_WIDTH) begin : g_nopad
      assign sum_top    = chunk_cout;
      assign bus.result = {carry_q, acc_q};
    end else begin : g_pad
      assign sum_top    = acc_shift[DATA_WIDTH];
      assign bus.result = acc_q[DATA_WIDTH:0];
    end
  endgenerate

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.borrow = borrow_q;

  // Next-state and datapath update for IDLE -> CALC -> DONE sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
`ifdef MPADDER_ZERO_FLAG_EN
    zacc_d   = zacc_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d     = PAD_WIDTH'(minuend);
          // Padding of the subtrahend is preset to ones so that the adder's
          // inversion turns it back into zeros.
          y_d     = PAD_WIDTH'(subtrahend) | (op_is_sub ? ~VALID_MASK : '0);
          sub_d   = op_is_sub;
          carry_d = op_is_sub;
          cnt_d   = '0;
          state_d = ST_CALC;
`ifdef MPADDER_ZERO_FLAG_EN
          zacc_d  = 1'b1;
          zero_d  = 1'b0;
`endif
        end
      end
      ST_CALC: begin
        x_d     = x_q >> ADDER_SIZE;
        y_d     = y_q >> ADDER_SIZE;
        acc_d   = acc_shift;
        carry_d = chunk_cout;
`ifdef MPADDER_ZERO_FLAG_EN
        zacc_d  = zacc_q & chunk_zero;
`endif
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          state_d  = ST_DONE;
          borrow_d = sub_q & ~sum_top;
`ifdef MPADDER_ZERO_FLAG_EN
          zero_d   = zacc_q & chunk_zero;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
`ifdef MPADDER_ZERO_FLAG_EN
      zacc_q   <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
`ifdef MPADDER_ZERO_FLAG_EN
      zacc_q   <= zacc_d;
      zero_q   <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_mpaddsub_seq.sv
// Testbench for mpaddsub_seq: five instances with different chunk sizes
// share one stimulus stream; a spec-level arithmetic model predicts busy,
// done timing, result, borrow (and zero when MPADDER_ZERO_FLAG_EN is set).
module tb_mpaddsub_seq;
  import mpadd_pkg::*;

  localparam int DW   = 1027;
  localparam int NCFG = 5;
  localparam int W    = DW + 2;

  function automatic int as_of(input int i);
    case (i)
      0:       return 257;
      1:       return 256;
      2:       return 1;
      3:       return 64;
      default: return 1027;
    endcase
  endfunction

  function automatic int cyc_of(input int i);
    return (DW + as_of(i) - 1) / as_of(i);
  endfunction

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] in_a, in_b;

  logic [DW:0]   res_w    [NCFG];
  logic          borrow_w [NCFG];
  logic          busy_w   [NCFG];
  logic          done_w   [NCFG];
`ifdef MPADDER_ZERO_FLAG_EN
  logic          zero_w   [NCFG];
`endif

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int AS = as_of(gi);
    mpaddsub_seq_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.start    = start;
    assign bus.mode     = mode;
    assign bus.in_a     = in_a;
    assign bus.in_b     = in_b;
    assign res_w[gi]    = bus.result;
    assign borrow_w[gi] = bus.borrow;
    assign busy_w[gi]   = bus.busy;
    assign done_w[gi]   = bus.done;
`ifdef MPADDER_ZERO_FLAG_EN
    assign zero_w[gi]   = bus.zero;
`endif
    mpaddsub_seq #(.DATA_WIDTH(DW), .ADDER_SIZE(AS)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  // Returns {borrow, carry/no-borrow, low DW bits} from plain arithmetic.
  function automatic logic [W-1:0] ref_op(input logic [1:0] md,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] low;
    logic          top, bw;
    case (md)
      MODE_SUB:  begin low = a - b; top = (a >= b); bw = (a < b); end
      MODE_RSUB: begin low = b - a; top = (b >= a); bw = (b < a); end
      default:   begin {top, low} = {1'b0, a} + {1'b0, b}; bw = 1'b0; end
    endcase
    return {bw, top, low};
  endfunction

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < 33; k++) v = (v << 32) | DW'($urandom());
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg=%0d got_hi=%h got_lo=%h exp_hi=%h exp_lo=%h",
               name, idx, act[W-1:W-32], act[127:0], exp[W-1:W-32], exp[127:0]);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          armed = 1'b0;
  logic          m_busy   [NCFG];
  int            m_cnt    [NCFG];
  logic          m_rst    [NCFG];
  logic [DW:0]   m_res    [NCFG];
  logic          m_borrow [NCFG];
  logic          m_zero   [NCFG];
  logic [DW:0]   p_res    [NCFG];
  logic          p_borrow [NCFG];
  logic          p_zero   [NCFG];

  // Track each instance: edges since accept, pending and visible results.
  always @(posedge clk) begin
    logic [W-1:0] r;
    r = ref_op(mode, in_a, in_b);
    if (reset) armed <= 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      if (reset) begin
        m_busy[i]   <= 1'b0;
        m_cnt[i]    <= 0;
        m_rst[i]    <= 1'b1;
        m_res[i]    <= '0;
        m_borrow[i] <= 1'b0;
        m_zero[i]   <= 1'b0;
      end else begin
        m_rst[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_cnt[i] == cyc_of(i)) begin
            m_cnt[i]    <= m_cnt[i] + 1;
            m_res[i]    <= p_res[i];
            m_borrow[i] <= p_borrow[i];
            m_zero[i]   <= p_zero[i];
          end else if (m_cnt[i] == cyc_of(i) + 1) begin
            m_busy[i] <= 1'b0;
          end else begin
            m_cnt[i] <= m_cnt[i] + 1;
          end
        end else if (start) begin
          m_busy[i]   <= 1'b1;
          m_cnt[i]    <= 1;
          p_res[i]    <= r[DW:0];
          p_borrow[i] <= r[DW+1];
          p_zero[i]   <= (r[DW-1:0] == '0);
        end
      end
    end
  end

  // Compare every instance against the model on the falling edge.
  always @(negedge clk) begin
    logic exp_done;
    if (armed) begin
      for (int i = 0; i < NCFG; i++) begin
        exp_done = m_busy[i] && (m_cnt[i] == cyc_of(i) + 1);
        check("busy", i, W'(busy_w[i]), W'(m_busy[i]));
        check("done", i, W'(done_w[i]), W'(exp_done));
        if (exp_done || m_rst[i] || (!m_busy[i] && start)) begin
          check("result", i, W'(res_w[i]), W'(m_res[i]));
          check("borrow", i, W'(borrow_w[i]), W'(m_borrow[i]));
`ifdef MPADDER_ZERO_FLAG_EN
          check("zero", i, W'(zero_w[i]), W'(m_zero[i]));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic any_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NCFG; i++) b = b | busy_w[i];
    return b;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (any_busy() && k < 3000) begin
      @(posedge clk); #2;
      k++;
    end
    checks++;
    if (k >= 3000) begin
      failures++;
      $display("FAIL wait_idle got=busy after %0d cycles exp=idle", k);
    end
  endtask

  // Issue one request; lat0 = cycle index of done on instance 0, counting
  // the cycle in which start was presented as 0.
  task automatic run_txn(input logic [1:0] md, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, output int lat0);
    start = 1'b1; mode = md; in_a = a; in_b = b;
    @(posedge clk); #2;
    start = 1'b0; mode = 2'($urandom()); in_a = rand_op(); in_b = rand_op();
    lat0 = 1;
    while (!done_w[0] && lat0 < 3000) begin
      @(posedge clk); #2;
      lat0++;
    end
    wait_idle();
  endtask

  logic [W-1:0]  e;
  logic [DW-1:0] p2;
  int            lat;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Pin the model itself against hand-computed values.
    p2 = '0; p2[DW-1] = 1'b1;
    e = '0; e[DW] = 1'b1;
    check("model_add", 0, ref_op(MODE_ADD, p2, p2), e);
    e = '1; e[0] = 1'b0; e[DW] = 1'b0;            // low = 2^1027-2, borrow=1
    check("model_sub", 0, ref_op(MODE_SUB, DW'(5), DW'(7)), e);
    e = '0; e[DW] = 1'b1; e[1] = 1'b1;            // low = 2, no-borrow = 1
    check("model_rsub", 0, ref_op(MODE_RSUB, DW'(5), DW'(7)), e);

    @(posedge clk); #2;

    // ADD 2^1026 + 2^1026 = carry only; latency CYCLES+1 = 5 for 257-bit chunks.
    run_txn(MODE_ADD, p2, p2, lat);
    check("latency_add", 0, W'(lat), W'(5));
    e = '0; e[DW] = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      check("add_res", i, W'(res_w[i]), e);
      check("add_borrow", i, W'(borrow_w[i]), W'(0));
    end

    // SUB 5-7 wraps with borrow.
    run_txn(MODE_SUB, DW'(5), DW'(7), lat);
    check("latency_sub", 0, W'(lat), W'(5));
    e = '1; e[0] = 1'b0; e[DW+1] = 1'b0; e[DW] = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      check("sub_res", i, W'(res_w[i]), e);
      check("sub_borrow", i, W'(borrow_w[i]), W'(1));
    end

    // RSUB 7-5 = 2 with no borrow.
    run_txn(MODE_RSUB, DW'(5), DW'(7), lat);
    e = '0; e[DW] = 1'b1; e[1] = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      check("rsub_res", i, W'(res_w[i]), e);
      check("rsub_borrow", i, W'(borrow_w[i]), W'(0));
    end

    // SUB all-ones minus all-ones: zero difference, padding masked off.
    run_txn(MODE_SUB, '1, '1, lat);
    e = '0; e[DW] = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      check("eq_res", i, W'(res_w[i]), e);
      check("eq_borrow", i, W'(borrow_w[i]), W'(0));
`ifdef MPADDER_ZERO_FLAG_EN
      check("eq_zero", i, W'(zero_w[i]), W'(1));
`endif
    end

    // Second start two cycles after accept must be ignored.
    start = 1'b1; mode = MODE_SUB; in_a = DW'(100); in_b = DW'(30);
    @(posedge clk); #2;
    start = 1'b0; in_a = rand_op(); in_b = rand_op();
    @(posedge clk); #2;
    start = 1'b1; mode = MODE_ADD; in_a = DW'(1); in_b = DW'(1);
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    e = '0; e[DW] = 1'b1; e[6:0] = 7'd70;
    for (int i = 0; i < NCFG; i++) begin
      check("ignore_res", i, W'(res_w[i]), e);
`ifdef MPADDER_ZERO_FLAG_EN
      check("ignore_zero", i, W'(zero_w[i]), W'(0));
`endif
    end

    // Reset sampled in the third CALC cycle aborts without a done pulse.
    start = 1'b1; mode = MODE_ADD; in_a = rand_op(); in_b = rand_op();
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      check("rst_busy", i, W'(busy_w[i]), W'(0));
      check("rst_done", i, W'(done_w[i]), W'(0));
      check("rst_res", i, W'(res_w[i]), W'(0));
    end
    repeat (4) begin @(posedge clk); #2; end

    // Fresh operation after the abort.
    run_txn(MODE_SUB, DW'(100), DW'(30), lat);
    check("latency_fresh", 0, W'(lat), W'(5));
    e = '0; e[DW] = 1'b1; e[6:0] = 7'd70;
    for (int i = 0; i < NCFG; i++) check("fresh_res", i, W'(res_w[i]), e);

    // Random sweep over all modes, checked by the model process.
    for (int t = 0; t < 6; t++) begin
      logic [DW-1:0] ra, rb;
      ra = rand_op();
      rb = (t == 2) ? ra : rand_op();
      run_txn(2'($urandom_range(0, 3)), ra, rb, lat);
      check("latency_rand", 0, W'(lat), W'(5));
    end

    repeat (3) begin @(posedge clk); #2; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
